// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC generator, 1-cycle ROM interface and instruction queue toward id
module fetch_queue #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'h1c000000)
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        rom_inst_en_o,
    output logic [ADDR_W-1:0]           rom_inst_addr_o,
    input  logic [INST_W-1:0]           rom_inst_i,
    input  logic                        redirect_i,
    input  logic [ADDR_W-1:0]           redirect_pc_i,
    input  logic                        id_ready_i,
    output logic                        id_valid_o,
    output logic [ADDR_W-1:0]           id_pc_o,
    output logic [INST_W-1:0]           id_inst_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              discard;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];

    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_nxt;

    // An in-flight fetch already owns a slot, so it counts toward occupancy.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight);
    assign issue     = !rst && !redirect_i && (occupancy < (CW+1)'(DEPTH));
    assign push      = inflight && !discard && !redirect_i;
    assign pop       = (count != '0) && id_ready_i && !redirect_i;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            discard     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
            inflight <= 1'b0;
            discard  <= inflight;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                fetch_pc    <= fetch_pc + ADDR_W'(4);
                inflight_pc <= fetch_pc;
            end
            inflight <= issue;
            discard  <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
        end
    end

    // Storage needs no reset; visibility is governed by count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_pc[wr_ptr]   <= inflight_pc;
            mem_inst[wr_ptr] <= rom_inst_i;
        end
    end

    assign rom_inst_en_o   = issue;
    assign rom_inst_addr_o = fetch_pc;
    assign id_valid_o      = (count != '0);
    assign id_pc_o         = id_valid_o ? mem_pc[rd_ptr]   : '0;
    assign id_inst_o       = id_valid_o ? mem_inst[rd_ptr] : '0;
    assign count_o         = count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

    localparam logic [31:0] RPC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_inst_en_o;
    logic [31:0] rom_inst_addr_o;
    logic [31:0] rom_data = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        id_ready_i = 1'b0;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h1c000000)) dut (
        .clk             (clk),
        .rst             (rst),
        .rom_inst_en_o   (rom_inst_en_o),
        .rom_inst_addr_o (rom_inst_addr_o),
        .rom_inst_i      (rom_data),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .id_ready_i      (id_ready_i),
        .id_valid_o      (id_valid_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .count_o         (count_o)
    );

    always #5 clk = ~clk;

    // ROM whose content equals its address, one cycle read latency
    always @(posedge clk)
        if (rom_inst_en_o)
            rom_data <= rom_inst_addr_o;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 after reset release.
    task automatic restart(input logic ready);
        rst = 1'b1;
        redirect_i = 1'b0;
        id_ready_i = ready;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_ready_i = 1'b1;
        cyc();
        cyc();
        checks++; if (rom_inst_en_o !== 1'b0) begin errors++; $display("FAIL reset_en got=%0b exp=0", rom_inst_en_o); end
        checks++; if (rom_inst_addr_o !== RPC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", rom_inst_addr_o, RPC); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", id_valid_o); end
        checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", id_pc_o); end
        checks++; if (id_inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", id_inst_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc;
        restart(1'b1);
        for (int k = 0; k < 10; k++) begin
            exp_pc = RPC + 32'(4 * k);
            checks++; if (rom_inst_en_o !== 1'b1 || rom_inst_addr_o !== exp_pc) begin
                errors++; $display("FAIL free_req cyc=%0d got en=%0b addr=%h exp en=1 addr=%h", k, rom_inst_en_o, rom_inst_addr_o, exp_pc); end
            checks++; if (id_valid_o !== (k >= 2)) begin
                errors++; $display("FAIL free_valid cyc=%0d got=%0b exp=%0b", k, id_valid_o, (k >= 2)); end
            if (k >= 2) begin
                exp_pc = RPC + 32'(4 * (k - 2));
                checks++; if (id_pc_o !== exp_pc || id_inst_o !== exp_pc) begin
                    errors++; $display("FAIL free_deliver cyc=%0d got pc=%h inst=%h exp=%h", k, id_pc_o, id_inst_o, exp_pc); end
            end
            cyc();
        end
    endtask

    task automatic test_stall();
        restart(1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++; if (rom_inst_en_o !== 1'b1 || rom_inst_addr_o !== RPC + 32'(4 * k)) begin
                errors++; $display("FAIL stall_req cyc=%0d got en=%0b addr=%h exp addr=%h", k, rom_inst_en_o, rom_inst_addr_o, RPC + 32'(4 * k)); end
            cyc();
        end
        checks++; if (rom_inst_en_o !== 1'b0) begin errors++; $display("FAIL stall_reserved_en got=%0b exp=0", rom_inst_en_o); end
        cyc();
        checks++; if (count_o !== 3'd4 || rom_inst_en_o !== 1'b0) begin
            errors++; $display("FAIL stall_full got count=%0d en=%0b exp count=4 en=0", count_o, rom_inst_en_o); end
        checks++; if (rom_inst_addr_o !== RPC + 32'h10) begin
            errors++; $display("FAIL stall_pc_hold got=%h exp=%h", rom_inst_addr_o, RPC + 32'h10); end
        id_ready_i = 1'b1;
        #1;
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== RPC) begin
            errors++; $display("FAIL stall_head got valid=%0b pc=%h exp pc=%h", id_valid_o, id_pc_o, RPC); end
        cyc();
        id_ready_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd3 || rom_inst_en_o !== 1'b1 || rom_inst_addr_o !== RPC + 32'h10) begin
            errors++; $display("FAIL stall_resume got count=%0d en=%0b addr=%h exp count=3 en=1 addr=%h", count_o, rom_inst_en_o, rom_inst_addr_o, RPC + 32'h10); end
        checks++; if (id_pc_o !== RPC + 32'h4) begin
            errors++; $display("FAIL stall_next_head got=%h exp=%h", id_pc_o, RPC + 32'h4); end
        cyc();
        checks++; if (rom_inst_en_o !== 1'b0) begin errors++; $display("FAIL stall_one_req got en=%0b exp=0", rom_inst_en_o); end
        cyc();
        checks++; if (count_o !== 3'd4 || rom_inst_en_o !== 1'b0) begin
            errors++; $display("FAIL stall_refull got count=%0d en=%0b exp count=4 en=0", count_o, rom_inst_en_o); end
    endtask

    task automatic test_redirect();
        restart(1'b0);
        cyc(); cyc(); cyc();
        checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL redir_setup got count=%0d exp=2", count_o); end
        redirect_i = 1'b1;
        redirect_pc_i = 32'h1c000103;
        #1;
        checks++; if (rom_inst_en_o !== 1'b0) begin errors++; $display("FAIL redir_no_issue got en=%0b exp=0", rom_inst_en_o); end
        cyc();
        redirect_i = 1'b0;
        id_ready_i = 1'b1;
        #1;
        checks++; if (count_o !== 3'd0 || id_valid_o !== 1'b0) begin
            errors++; $display("FAIL redir_flush got count=%0d valid=%0b exp 0 0", count_o, id_valid_o); end
        checks++; if (rom_inst_en_o !== 1'b1 || rom_inst_addr_o !== 32'h1c000100) begin
            errors++; $display("FAIL redir_req got en=%0b addr=%h exp addr=1c000100", rom_inst_en_o, rom_inst_addr_o); end
        cyc();
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL redir_stale got valid=%0b pc=%h exp valid=0", id_valid_o, id_pc_o); end
        cyc();
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h1c000100 || id_inst_o !== 32'h1c000100) begin
            errors++; $display("FAIL redir_first got valid=%0b pc=%h inst=%h exp pc=1c000100", id_valid_o, id_pc_o, id_inst_o); end
    endtask

    task automatic test_pop_push_full();
        logic [31:0] exp_pc;
        restart(1'b0);
        cyc(); cyc(); cyc(); cyc();
        checks++; if (count_o !== 3'd3 || rom_inst_en_o !== 1'b0) begin
            errors++; $display("FAIL full_setup got count=%0d en=%0b exp count=3 en=0", count_o, rom_inst_en_o); end
        id_ready_i = 1'b1;
        exp_pc = RPC;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (id_valid_o !== 1'b1 || id_pc_o !== exp_pc || id_inst_o !== exp_pc) begin
                errors++; $display("FAIL full_seq step=%0d got valid=%0b pc=%h inst=%h exp=%h", k, id_valid_o, id_pc_o, id_inst_o, exp_pc); end
            exp_pc = exp_pc + 32'h4;
            cyc();
            if (k == 0) begin
                checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL full_count_hold got=%0d exp=3", count_o); end
            end
        end
    endtask

    task automatic test_redirect_pop();
        restart(1'b0);
        cyc(); cyc();
        checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL rpop_setup got count=%0d exp=1", count_o); end
        id_ready_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h1c000200;
        #1;
        checks++; if (rom_inst_en_o !== 1'b0) begin errors++; $display("FAIL rpop_no_issue got en=%0b exp=0", rom_inst_en_o); end
        cyc();
        redirect_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd0 || id_valid_o !== 1'b0) begin
            errors++; $display("FAIL rpop_empty got count=%0d valid=%0b exp 0 0", count_o, id_valid_o); end
        checks++; if (rom_inst_en_o !== 1'b1 || rom_inst_addr_o !== 32'h1c000200) begin
            errors++; $display("FAIL rpop_req got en=%0b addr=%h exp addr=1c000200", rom_inst_en_o, rom_inst_addr_o); end
        cyc();
        cyc();
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h1c000200) begin
            errors++; $display("FAIL rpop_first got valid=%0b pc=%h exp pc=1c000200", id_valid_o, id_pc_o); end
    endtask

    task automatic test_back_to_back();
        restart(1'b1);
        cyc(); cyc();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h1c000300;
        cyc();
        redirect_pc_i = 32'h1c000404;
        #1;
        checks++; if (rom_inst_en_o !== 1'b0) begin errors++; $display("FAIL b2b_no_issue got en=%0b exp=0", rom_inst_en_o); end
        cyc();
        redirect_i = 1'b0;
        #1;
        checks++; if (rom_inst_addr_o !== 32'h1c000404 || rom_inst_en_o !== 1'b1) begin
            errors++; $display("FAIL b2b_last_wins got en=%0b addr=%h exp addr=1c000404", rom_inst_en_o, rom_inst_addr_o); end
        cyc();
        cyc();
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h1c000404) begin
            errors++; $display("FAIL b2b_first got valid=%0b pc=%h exp pc=1c000404", id_valid_o, id_pc_o); end
    endtask

    task automatic test_reset_mid();
        restart(1'b0);
        cyc(); cyc(); cyc(); cyc();
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL rmid_setup got count=%0d exp=3", count_o); end
        rst = 1'b1;
        #1;
        checks++; if (rom_inst_en_o !== 1'b0) begin errors++; $display("FAIL rmid_en got=%0b exp=0", rom_inst_en_o); end
        cyc();
        checks++; if (count_o !== 3'd0 || id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_inst_o !== 32'h0 || rom_inst_addr_o !== RPC) begin
            errors++; $display("FAIL rmid_state got count=%0d valid=%0b pc=%h inst=%h addr=%h", count_o, id_valid_o, id_pc_o, id_inst_o, rom_inst_addr_o); end
        rst = 1'b0;
        id_ready_i = 1'b1;
        #1;
        checks++; if (rom_inst_en_o !== 1'b1 || rom_inst_addr_o !== RPC) begin
            errors++; $display("FAIL rmid_restart got en=%0b addr=%h exp addr=%h", rom_inst_en_o, rom_inst_addr_o, RPC); end
        cyc();
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_stale got valid=%0b pc=%h exp valid=0", id_valid_o, id_pc_o); end
        cyc();
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== RPC || id_inst_o !== RPC) begin
            errors++; $display("FAIL rmid_first got valid=%0b pc=%h inst=%h exp=%h", id_valid_o, id_pc_o, id_inst_o, RPC); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_pop_push_full();
        test_redirect_pop();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
